// File: rtl/gb_cpu_instr_fetch.sv
// Game Boy CPU instruction fetch unit.
// Reads one byte per acknowledged request starting at pc and assembles each
// opcode, together with its optional CB prefix or 8/16-bit immediate, into a
// single instruction packet handed to the decoder via a valid/ready handshake.

package gb_cpu_common_pkg;

  // Which byte of the current instruction the fetch unit is waiting for.
  typedef enum logic [2:0] {
    READ_OPCODE    = 3'd0,
    READ_CB_OPCODE = 3'd1,
    READ_R8        = 3'd2,
    READ_R16_BYTE0 = 3'd3,
    READ_R16_BYTE1 = 3'd4
  } decoder_state_t;

endpackage

module gb_cpu_instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic        instr_cb,
  output logic [15:0] instr_imm,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc
);

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  gb_cpu_common_pkg::decoder_state_t state_q, state_d;

  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        cb_q, cb_d;
  logic [15:0] imm_q, imm_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] ipc_q, ipc_d;

  logic        consume;

  // Opcodes followed by one immediate byte (d8, r8 or a8 operand).
  function automatic logic has_imm8(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Opcodes followed by a little-endian 16-bit immediate (d16 or a16 operand).
  function automatic logic has_imm16(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
      8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
      8'hEA, 8'hFA: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Memory is only asked for a byte when there is room for a new packet and
  // no redirect is pending; a byte is taken only when the request is acked.
  assign mem_req  = !valid_q && !pc_load;
  assign mem_addr = pc_q;
  assign consume  = mem_req && mem_ack;

  assign instr_valid  = valid_q;
  assign instr_opcode = opcode_q;
  assign instr_cb     = cb_q;
  assign instr_imm    = imm_q;
  assign instr_len    = len_q;
  assign instr_pc     = ipc_q;

  // Register all fetch state; reset discards any partially fetched instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= gb_cpu_common_pkg::READ_OPCODE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      opcode_q <= 8'h00;
      cb_q     <= 1'b0;
      imm_q    <= 16'h0000;
      len_q    <= 2'd0;
      ipc_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      cb_q     <= cb_d;
      imm_q    <= imm_d;
      len_q    <= len_d;
      ipc_q    <= ipc_d;
    end
  end

  // Next-state logic: a redirect wins over everything, otherwise the handshake
  // retires the current packet and each consumed byte advances the assembly.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    opcode_d = opcode_q;
    cb_d     = cb_q;
    imm_d    = imm_q;
    len_d    = len_q;
    ipc_d    = ipc_q;

    if (pc_load) begin
      pc_d    = pc_load_value;
      state_d = gb_cpu_common_pkg::READ_OPCODE;
      valid_d = 1'b0;
    end else begin
      if (valid_q && instr_ready) begin
        valid_d = 1'b0;
      end

      if (consume) begin
        pc_d = pc_q + 16'd1;
        case (state_q)
          gb_cpu_common_pkg::READ_OPCODE: begin
            ipc_d    = pc_q;
            opcode_d = mem_rdata;
            cb_d     = 1'b0;
            imm_d    = 16'h0000;
            if (mem_rdata == CB_PREFIX) begin
              state_d = gb_cpu_common_pkg::READ_CB_OPCODE;
            end else if (has_imm8(mem_rdata)) begin
              state_d = gb_cpu_common_pkg::READ_R8;
            end else if (has_imm16(mem_rdata)) begin
              state_d = gb_cpu_common_pkg::READ_R16_BYTE0;
            end else begin
              len_d   = 2'd1;
              valid_d = 1'b1;
            end
          end
          gb_cpu_common_pkg::READ_CB_OPCODE: begin
            opcode_d = mem_rdata;
            cb_d     = 1'b1;
            imm_d    = 16'h0000;
            len_d    = 2'd2;
            valid_d  = 1'b1;
            state_d  = gb_cpu_common_pkg::READ_OPCODE;
          end
          gb_cpu_common_pkg::READ_R8: begin
            imm_d   = {8'h00, mem_rdata};
            len_d   = 2'd2;
            valid_d = 1'b1;
            state_d = gb_cpu_common_pkg::READ_OPCODE;
          end
          gb_cpu_common_pkg::READ_R16_BYTE0: begin
            imm_d   = {8'h00, mem_rdata};
            state_d = gb_cpu_common_pkg::READ_R16_BYTE1;
          end
          gb_cpu_common_pkg::READ_R16_BYTE1: begin
            imm_d   = {mem_rdata, imm_q[7:0]};
            len_d   = 2'd3;
            valid_d = 1'b1;
            state_d = gb_cpu_common_pkg::READ_OPCODE;
          end
          default: begin
            state_d = gb_cpu_common_pkg::READ_OPCODE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_cpu_instr_fetch.sv
// Testbench for gb_cpu_instr_fetch.
// A memory image answers fetches with random acknowledge timing; expected
// packets come from a byte-level decode of that image and are checked by a
// negedge monitor against a queue filled when each fetch stream is started.

module tb_gb_cpu_instr_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [7:0]  opcode;
    logic        cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
  } packet_t;

  logic        clk;
  logic        rst_n;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic        instr_cb;
  logic [15:0] instr_imm;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;

  logic [7:0]  mem_image [65536];
  packet_t     exp_q [$];
  packet_t     mon_pkt;
  logic [15:0] fetch_ptr;
  int          vectors = 0;
  int          miscompares = 0;
  int          ack_pct = 100;
  int          ready_pct = 100;

  logic [7:0] n8_list [25] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                               8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6,
                               8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8,
                               8'hF8};
  logic [7:0] n16_list [17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA,
                                8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA,
                                8'hFA};

  gb_cpu_instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_cb      (instr_cb),
    .instr_imm     (instr_imm),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_image[mem_addr];

  function automatic bit in_n8(input logic [7:0] op);
    foreach (n8_list[i]) if (n8_list[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_n16(input logic [7:0] op);
    foreach (n16_list[i]) if (n16_list[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference decode of one instruction straight from the memory image.
  function automatic packet_t decode_at(input logic [15:0] a);
    packet_t p;
    logic [7:0] op;
    op = mem_image[a];
    p.pc = a;
    p.cb = 1'b0;
    p.opcode = op;
    p.imm = 16'h0000;
    p.len = 2'd1;
    if (op == 8'hCB) begin
      p.opcode = mem_image[a + 16'd1];
      p.cb = 1'b1;
      p.len = 2'd2;
    end else if (in_n8(op)) begin
      p.imm = {8'h00, mem_image[a + 16'd1]};
      p.len = 2'd2;
    end else if (in_n16(op)) begin
      p.imm = {mem_image[a + 16'd2], mem_image[a + 16'd1]};
      p.len = 2'd3;
    end
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic flagTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out with %0d packets outstanding", name, exp_q.size());
  endtask

  function automatic void pushPkt(input logic [7:0] op, input logic cb, input logic [15:0] imm,
                                  input logic [1:0] len, input logic [15:0] pc);
    packet_t p;
    p.opcode = op;
    p.cb = cb;
    p.imm = imm;
    p.len = len;
    p.pc = pc;
    exp_q.push_back(p);
  endfunction

  function automatic void pushModel(input logic [15:0] addr, input int n);
    logic [15:0] a;
    packet_t p;
    a = addr;
    for (int k = 0; k < n; k++) begin
      p = decode_at(a);
      exp_q.push_back(p);
      a = a + {14'd0, p.len};
    end
  endfunction

  // Writes n random instructions of mixed kinds into the image at addr.
  function automatic void genInstr(input logic [15:0] addr, input int n);
    logic [15:0] a;
    logic [7:0] op;
    a = addr;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          do op = 8'($urandom); while (op == 8'hCB || in_n8(op) || in_n16(op));
          mem_image[a] = op;
          a = a + 16'd1;
        end
        1: begin
          mem_image[a] = 8'hCB;
          mem_image[a + 16'd1] = 8'($urandom);
          a = a + 16'd2;
        end
        2: begin
          mem_image[a] = n8_list[$urandom_range(0, 24)];
          mem_image[a + 16'd1] = 8'($urandom);
          a = a + 16'd2;
        end
        default: begin
          mem_image[a] = n16_list[$urandom_range(0, 16)];
          mem_image[a + 16'd1] = 8'($urandom);
          mem_image[a + 16'd2] = 8'($urandom);
          a = a + 16'd3;
        end
      endcase
    end
  endfunction

  // One clock of stimulus: random ack, ready only while packets are expected.
  task automatic tick();
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    mem_ack = (int'($urandom_range(0, 99)) < ack_pct);
    instr_ready = (exp_q.size() > 0) && (int'($urandom_range(0, 99)) < ready_pct);
  endtask

  // Redirect fetch to addr; anything still expected from the old stream is void.
  task automatic applyStimulus(input logic [15:0] addr);
    tick();
    pc_load = 1'b1;
    pc_load_value = addr;
    exp_q.delete();
  endtask

  task automatic waitDrain(input int max_cycles, input string name);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < max_cycles) begin
      tick();
      i++;
    end
    if (exp_q.size() > 0) begin
      flagTimeout(name);
      exp_q.delete();
    end
  endtask

  task automatic waitFetchPtr(input logic [15:0] target, input int max_cycles, input string name);
    int i;
    i = 0;
    while (fetch_ptr != target && i < max_cycles) begin
      tick();
      i++;
    end
    if (fetch_ptr != target) flagTimeout(name);
  endtask

  // Monitor: tracks the expected fetch address and scores presented packets.
  always @(negedge clk) begin
    if (!rst_n) begin
      fetch_ptr = RESET_PC;
    end else begin
      checkOutput("mem_req", {15'd0, mem_req}, {15'd0, (!instr_valid && !pc_load)});
      checkOutput("mem_addr", mem_addr, fetch_ptr);
      if (pc_load) fetch_ptr = pc_load_value;
      else if (mem_req && mem_ack) fetch_ptr = fetch_ptr + 16'd1;
      if (instr_valid && !pc_load) begin
        if (exp_q.size() > 0) begin
          mon_pkt = exp_q[0];
          checkOutput("opcode", {8'h00, instr_opcode}, {8'h00, mon_pkt.opcode});
          checkOutput("cb", {15'd0, instr_cb}, {15'd0, mon_pkt.cb});
          checkOutput("imm", instr_imm, mon_pkt.imm);
          checkOutput("len", {14'd0, instr_len}, {14'd0, mon_pkt.len});
          checkOutput("instr_pc", instr_pc, mon_pkt.pc);
          if (instr_ready) void'(exp_q.pop_front());
        end else if (instr_ready) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_packet: actual op=%h pc=%h required none", instr_opcode, instr_pc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    pc_load = 1'b0;
    pc_load_value = 16'h0000;
    mem_ack = 1'b0;
    instr_ready = 1'b0;
    fetch_ptr = RESET_PC;
    for (int i = 0; i < 65536; i++) mem_image[i] = 8'($urandom);
    mem_image[16'h0000] = 8'h00; mem_image[16'h0001] = 8'h3E; mem_image[16'h0002] = 8'h42;
    mem_image[16'h0100] = 8'hCB; mem_image[16'h0101] = 8'h37;
    mem_image[16'h0200] = 8'hC3; mem_image[16'h0201] = 8'h11; mem_image[16'h0202] = 8'h22;
    mem_image[16'h0038] = 8'h00;
    mem_image[16'h0300] = 8'h3E; mem_image[16'h0301] = 8'h55;
    mem_image[16'hFFFE] = 8'hC3; mem_image[16'hFFFF] = 8'h50;

    // Reset values.
    #12;
    checkOutput("rst_valid", {15'd0, instr_valid}, 16'd0);
    checkOutput("rst_opcode", {8'h00, instr_opcode}, 16'd0);
    checkOutput("rst_cb", {15'd0, instr_cb}, 16'd0);
    checkOutput("rst_imm", instr_imm, 16'd0);
    checkOutput("rst_len", {14'd0, instr_len}, 16'd0);
    checkOutput("rst_instr_pc", instr_pc, 16'd0);
    checkOutput("rst_mem_addr", mem_addr, RESET_PC);
    checkOutput("rst_mem_req", {15'd0, mem_req}, 16'd1);

    // 00, 3E 42 from reset with ack and ready every cycle.
    pushPkt(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000);
    pushPkt(8'h3E, 1'b0, 16'h0042, 2'd2, 16'h0001);
    rst_n = 1'b1;
    waitDrain(50, "reset_stream");

    // CB 37 at 0x0100, held for five stalled cycles before acceptance.
    applyStimulus(16'h0100);
    pushPkt(8'h37, 1'b1, 16'h0000, 2'd2, 16'h0100);
    ready_pct = 0;
    begin
      int i;
      i = 0;
      while (!instr_valid && i < 50) begin tick(); i++; end
      if (!instr_valid) flagTimeout("cb_valid");
    end
    repeat (5) begin
      tick();
      checkOutput("stall_mem_req", {15'd0, mem_req}, 16'd0);
      checkOutput("stall_valid", {15'd0, instr_valid}, 16'd1);
    end
    ready_pct = 100;
    waitDrain(50, "cb_stream");
    checkOutput("valid_fall", {15'd0, instr_valid}, 16'd0);
    checkOutput("mem_req_resume", {15'd0, mem_req}, 16'd1);
    checkOutput("pc_after_cb", mem_addr, 16'h0102);

    // Redirect to 0x0038 while waiting for the last byte of C3 11 22.
    applyStimulus(16'h0200);
    waitFetchPtr(16'h0202, 20, "reach_byte1");
    pc_load = 1'b1;
    pc_load_value = 16'h0038;
    mem_ack = 1'b1;
    pushPkt(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0038);
    tick();
    checkOutput("flush_valid", {15'd0, instr_valid}, 16'd0);
    checkOutput("flush_addr", mem_addr, 16'h0038);
    waitDrain(50, "after_flush");

    // Reset pulse while waiting for the immediate of 3E 55.
    applyStimulus(16'h0300);
    waitFetchPtr(16'h0301, 20, "reach_r8");
    mem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {15'd0, instr_valid}, 16'd0);
    checkOutput("midrst_addr", mem_addr, RESET_PC);
    pushPkt(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000);
    pushPkt(8'h3E, 1'b0, 16'h0042, 2'd2, 16'h0001);
    #3 rst_n = 1'b1;
    waitDrain(50, "post_reset_stream");

    // C3 50 01 straddling 0xFFFF -> 0x0000.
    mem_image[16'h0000] = 8'h01;
    applyStimulus(16'hFFFE);
    pushPkt(8'hC3, 1'b0, 16'h0150, 2'd3, 16'hFFFE);
    waitDrain(50, "wrap_stream");

    // Random streams with random handshake timing and occasional early redirect.
    ack_pct = 60;
    ready_pct = 70;
    for (int seg = 0; seg < 60; seg++) begin
      logic [15:0] addr;
      int n;
      addr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) addr = 16'hFFFD + 16'($urandom_range(0, 2));
      n = $urandom_range(1, 6);
      applyStimulus(addr);
      genInstr(addr, n);
      pushModel(addr, n);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 20)) tick();
      end else begin
        waitDrain(3000, "random_stream");
      end
    end
    waitDrain(3000, "final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
